// File: rtl/ecc_scrub_controller.sv
// Background SEC-DED scrubber and single-port RAM arbiter: walks every address, rewrites
// single-bit-corrected words and logs error counts. Optional error IRQ: SCRUB_ERR_IRQ_EN.
module ecc_scrub_controller #(
  parameter int DATA_BITS    = 64,
  parameter int ADDR_BITS    = 10,
  parameter int DEPTH        = 1024,
  parameter int INTERVAL     = 4096,
  parameter int PIPE_LATENCY = 2,
  parameter int COUNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_enable,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_BITS-1:0]  host_addr,
  output logic                  host_grant,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic                  ram_wsel_scrub,
  input  logic                  dec_valid,
  input  logic [DATA_BITS-1:0]  dec_data,
  input  logic                  dec_correctable,
  input  logic                  dec_uncorrectable,
  output logic                  enc_valid,
  output logic [DATA_BITS-1:0]  enc_data,
  input  logic                  enc_out_valid,
  output logic                  busy,
  output logic                  pass_done,
  output logic [COUNT_BITS-1:0] corr_count,
  output logic [COUNT_BITS-1:0] uncorr_count,
  output logic [ADDR_BITS-1:0]  last_err_addr
`ifdef SCRUB_ERR_IRQ_EN
  ,
  input  logic                  irq_clear,
  output logic                  err_irq
`endif
);

  localparam int TIMER_BITS = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int WAIT_BITS  = $clog2(PIPE_LATENCY + 1);

  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(INTERVAL - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE  = TIMER_BITS'(1);
  localparam logic [WAIT_BITS-1:0]  WAIT_LAST  = WAIT_BITS'(PIPE_LATENCY);
  localparam logic [WAIT_BITS-1:0]  WAIT_ONE   = WAIT_BITS'(1);
  localparam logic [ADDR_BITS-1:0]  ADDR_LAST  = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0]  ADDR_ONE   = ADDR_BITS'(1);
  localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RDWAIT,
    S_ENCWAIT,
    S_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q;
  logic [WAIT_BITS-1:0]  wait_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  issue_rd;
  logic                  log_corr;
  logic                  log_uncorr;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    host_grant     = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wsel_scrub = 1'b0;
    enc_valid      = 1'b0;
    enc_data       = '0;
    busy           = 1'b0;
    pass_done      = 1'b0;
    issue_rd       = 1'b0;
    log_corr       = 1'b0;
    log_uncorr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        host_grant = host_req;
        if (scrub_enable && timer_q == TIMER_LAST) state_d = S_ARB;
      end
      S_ARB: begin
        host_grant = host_req;
        if (!host_req) begin
          issue_rd = 1'b1;
          ram_en   = 1'b1;
          ram_addr = addr_q;
          state_d  = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        busy = 1'b1;
        // Only the cycle matching our own read is ours; other decoder results belong to the host.
        if (wait_q == WAIT_LAST) begin
          if (!dec_valid || dec_uncorrectable) begin
            log_uncorr = 1'b1;
            state_d    = S_NEXT;
          end else if (dec_correctable) begin
            log_corr  = 1'b1;
            enc_valid = 1'b1;
            enc_data  = dec_data;
            state_d   = S_ENCWAIT;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_ENCWAIT: begin
        busy = 1'b1;
        if (enc_out_valid) begin
          ram_en         = 1'b1;
          ram_we         = 1'b1;
          ram_wsel_scrub = 1'b1;
          ram_addr       = addr_q;
          state_d        = S_NEXT;
        end
      end
      S_NEXT: begin
        busy      = 1'b1;
        pass_done = (addr_q == ADDR_LAST);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Grant is only possible in IDLE/ARB, where the scrub side is not driving the port.
    if (host_grant) begin
      ram_en   = 1'b1;
      ram_we   = host_we;
      ram_addr = host_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && scrub_enable && timer_q != TIMER_LAST)
        timer_q <= timer_q + TIMER_ONE;
      else
        timer_q <= '0;

      if (issue_rd)
        wait_q <= WAIT_ONE;
      else if (state_q == S_RDWAIT && wait_q != WAIT_LAST)
        wait_q <= wait_q + WAIT_ONE;

      if (state_q == S_NEXT)
        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count    <= '0;
      uncorr_count  <= '0;
      last_err_addr <= '0;
    end else begin
      if (log_corr && corr_count != '1)     corr_count   <= corr_count + COUNT_ONE;
      if (log_uncorr && uncorr_count != '1) uncorr_count <= uncorr_count + COUNT_ONE;
      if (log_corr || log_uncorr)           last_err_addr <= addr_q;
    end
  end

`ifdef SCRUB_ERR_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_irq <= 1'b0;
    else if (log_corr || log_uncorr)  err_irq <= 1'b1;
    else if (irq_clear)               err_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Randomized bench for ecc_scrub_controller: the bench plays RAM, decoder and encoder and
// predicts every cycle from a transaction-level model of the scrub rules.
module tb_ecc_scrub_controller;

  localparam int DW = 16, AW = 3, DEPTH = 4, INTERVAL = 4, PL = 2, CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic scrub_enable = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic host_grant, ram_en, ram_we, ram_wsel_scrub, enc_valid, busy, pass_done;
  logic [AW-1:0] ram_addr, last_err_addr;
  logic dec_valid = 1'b0, dec_correctable = 1'b0, dec_uncorrectable = 1'b0, enc_out_valid = 1'b0;
  logic [DW-1:0] dec_data = '0;
  logic [DW-1:0] enc_data;
  logic [CW-1:0] corr_count, uncorr_count;
`ifdef SCRUB_ERR_IRQ_EN
  logic irq_clear = 1'b0;
  logic err_irq;
`endif

  ecc_scrub_controller #(
    .DATA_BITS(DW), .ADDR_BITS(AW), .DEPTH(DEPTH), .INTERVAL(INTERVAL),
    .PIPE_LATENCY(PL), .COUNT_BITS(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scrub_enable(scrub_enable),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_grant(host_grant),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wsel_scrub(ram_wsel_scrub),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_correctable(dec_correctable),
    .dec_uncorrectable(dec_uncorrectable), .enc_valid(enc_valid), .enc_data(enc_data),
    .enc_out_valid(enc_out_valid), .busy(busy), .pass_done(pass_done),
    .corr_count(corr_count), .uncorr_count(uncorr_count), .last_err_addr(last_err_addr)
`ifdef SCRUB_ERR_IRQ_EN
    , .irq_clear(irq_clear), .err_irq(err_irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Environment: RAM contents, per-word error state (0 clean, 1 single, 2 double), read returns.
  logic [DW-1:0] mem_data [8];
  int            mem_err  [8];
  bit            rsp_v    [16];
  bit            rsp_drop [16];
  logic [AW-1:0] rsp_a    [16];
  bit            enc_pend;
  logic [DW-1:0] enc_word;
  bit            drop_en;
  int            scrub_wr [8];
  int            pass_cnt;

  // Reference model.
  int m_addr, m_corr, m_uncorr, m_last, idle_run, issue_at, finish_at;
  bit await_enc, m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_idle();
    return issue_at < 0 && !await_enc && finish_at < 0;
  endfunction

  task automatic model_clear();
    m_addr = 0; m_corr = 0; m_uncorr = 0; m_last = 0; idle_run = 0;
    issue_at = -1; finish_at = -1; await_enc = 0; m_irq = 0; enc_pend = 0;
    for (int i = 0; i < 16; i++) rsp_v[i] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; scrub_enable = 1'b0;
    dec_valid = 1'b0; dec_data = '0; dec_correctable = 1'b0; dec_uncorrectable = 1'b0;
    enc_out_valid = 1'b0;
`ifdef SCRUB_ERR_IRQ_EN
    irq_clear = 1'b0;
`endif
    #2;
    check("rst_ctl", {host_grant, ram_en, ram_we, ram_wsel_scrub, enc_valid, busy, pass_done}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_corr", corr_count, 0);
    check("rst_uncorr", uncorr_count, 0);
    check("rst_last", last_err_addr, 0);
`ifdef SCRUB_ERR_IRQ_EN
    check("rst_irq", err_irq, 0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cycle(input bit h_req, input bit h_we, input logic [AW-1:0] h_addr,
                       input bit en, input bit clr);
    int k;
    bit log_c, log_u, e_grant, e_busy, e_encv, e_pass;
    logic [AW+2:0] e_ram;
    logic [DW-1:0] e_encd;
    @(posedge clk); #1;
    cyc++;
    host_req = h_req; host_we = h_we; host_addr = h_addr; scrub_enable = en;
`ifdef SCRUB_ERR_IRQ_EN
    irq_clear = clr;
`endif
    k = cyc % 16;
    if (rsp_v[k]) begin
      dec_valid         = !rsp_drop[k];
      dec_data          = mem_data[rsp_a[k]];
      dec_correctable   = (mem_err[rsp_a[k]] == 1);
      dec_uncorrectable = (mem_err[rsp_a[k]] == 2);
      rsp_v[k] = 0;
    end else begin
      dec_valid = 0; dec_data = DW'($urandom); dec_correctable = 0; dec_uncorrectable = 0;
    end
    enc_out_valid = enc_pend;
    enc_pend = 0;
    @(negedge clk);

    log_c = 0; log_u = 0; e_grant = 0; e_busy = 0; e_encv = 0; e_pass = 0;
    e_ram = '0; e_encd = '0;
    if (model_idle()) begin
      e_grant = h_req;
      if (idle_run >= INTERVAL && !h_req) begin
        e_ram = {3'b100, AW'(m_addr)};
        issue_at = cyc;
      end else if (h_req) begin
        e_ram = {1'b1, h_we, 1'b0, h_addr};
      end
      if (idle_run < INTERVAL) idle_run = en ? idle_run + 1 : 0;
    end else begin
      e_busy = 1;
      if (issue_at >= 0 && cyc == issue_at + PL) begin
        if (!dec_valid || dec_uncorrectable) log_u = 1;
        else if (dec_correctable)            log_c = 1;
        if (log_c) begin
          e_encv = 1; e_encd = dec_data; await_enc = 1;
        end else begin
          finish_at = cyc + 1;
        end
        issue_at = -1;
      end else if (await_enc && enc_out_valid) begin
        e_ram = {3'b111, AW'(m_addr)};
        await_enc = 0;
        finish_at = cyc + 1;
      end else if (finish_at == cyc) begin
        e_pass = (m_addr == DEPTH - 1);
        m_addr = (m_addr + 1) % DEPTH;
        finish_at = -1;
        idle_run = 0;
      end
    end

    check("host_grant", host_grant, e_grant);
    check("ram_port", {ram_en, ram_we, ram_wsel_scrub, ram_addr}, e_ram);
    check("busy", busy, e_busy);
    check("enc_valid", enc_valid, e_encv);
    check("enc_data", enc_data, e_encd);
    check("pass_done", pass_done, e_pass);
    check("corr_count", corr_count, m_corr);
    check("uncorr_count", uncorr_count, m_uncorr);
    check("last_err_addr", last_err_addr, m_last);
`ifdef SCRUB_ERR_IRQ_EN
    check("err_irq", err_irq, m_irq);
    m_irq = (log_c || log_u) ? 1'b1 : (clr ? 1'b0 : m_irq);
`endif
    if (log_c) begin
      if (m_corr < CMAX) m_corr++;
      m_last = m_addr;
    end
    if (log_u) begin
      if (m_uncorr < CMAX) m_uncorr++;
      m_last = m_addr;
    end

    // Environment reacts to what the DUT actually drove.
    if (pass_done) pass_cnt++;
    if (ram_en && !ram_we) begin
      rsp_v[(cyc + PL) % 16]    = 1;
      rsp_a[(cyc + PL) % 16]    = ram_addr;
      rsp_drop[(cyc + PL) % 16] = drop_en && ($urandom_range(15) == 0);
    end
    if (ram_en && ram_we) begin
      if (ram_wsel_scrub) begin
        mem_data[ram_addr] = enc_word;
        scrub_wr[ram_addr]++;
      end else begin
        mem_data[ram_addr] = DW'($urandom);
      end
      mem_err[ram_addr] = 0;
    end
    if (enc_valid) begin
      enc_pend = 1;
      enc_word = enc_data;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 1, 0);
  endtask

  initial begin
    int sum, a;
    bit found;
    for (int i = 0; i < 8; i++) begin
      mem_data[i] = DW'($urandom); mem_err[i] = 0; scrub_wr[i] = 0;
    end
    drop_en = 0; pass_cnt = 0;
    model_clear();
    do_reset();

    // Clean RAM: exactly one full pass, no rewrites.
    idle_cycles(40);
    check("clean_passes", pass_cnt, 1);
    sum = 0;
    for (int i = 0; i < 8; i++) sum += scrub_wr[i];
    check("clean_no_writes", sum, 0);

    // Single-bit error at 2 gets rewritten once; double-bit error at 1 never does.
    mem_err[2] = 1;
    mem_err[1] = 2;
    idle_cycles(80);
    check("wr_addr2", scrub_wr[2], 1);
    check("wr_addr1", scrub_wr[1], 0);
    check("uncorr_seen", uncorr_count != 0, 1);
    mem_err[1] = 0;

    // Hold the host on the port in ARB for 10 cycles.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, 0, '0, 1, 0);
      found = model_idle() && idle_run >= INTERVAL;
    end
    check("arb_reached", found, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, AW'($urandom_range(7)), 1, 0);
      check("hold_grant", host_grant, 1);
    end
    cycle(0, 0, '0, 1, 0);
    check("post_hold_issue", {ram_en, ram_we}, 2'b10);
    idle_cycles(20);

    // Randomized traffic, errors, dropped decoder results and enable toggling.
    drop_en = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(29) == 0) begin
        a = $urandom_range(7);
        mem_err[a] = (mem_err[a] == 2) ? 2 : int'($urandom_range(2, 1));
      end
      cycle($urandom_range(3) == 0, $urandom_range(1) == 1, AW'($urandom_range(7)),
            $urandom_range(31) != 0, $urandom_range(7) == 0);
    end
    check("corr_saturated", corr_count, CMAX);
    check("uncorr_saturated", uncorr_count, CMAX);
    drop_en = 0;

    // Reset while waiting on the encoder: the rewrite must never happen.
    a = m_addr;
    mem_err[a] = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(0, 0, '0, 1, 0);
      found = await_enc;
    end
    check("encwait_reached", found, 1);
    sum = scrub_wr[a];
    do_reset();
    check("abort_no_write", scrub_wr[a], sum);
    check("abort_err_kept", mem_err[a], 1);
    idle_cycles(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
